uart_tx_fifo_drain: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx_fifo_drain.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the fifo-draining UART transmitter.
// The PARITY state exists only when UART_TX_FIFO_DRAIN_PARITY_EN is defined.
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: free-runs 0..CLK_DIV-1 while clr_i is low and flags the
// last cycle of each serial bit with a one-cycle tick.
module uart_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int             CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from an 8-bit fifo (one-cycle read latency) and sends each as an
// async UART frame. Define UART_TX_FIFO_DRAIN_PARITY_EN to add an even parity bit.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rd_empty_i,
    output logic       rd_stb_o,
    input  logic [7:0] rd_dat_i,
    output logic       tx_o,
    output logic       busy_o
);

    localparam logic       STOP_LAST = (STOP_BITS == 2);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    uart_tx_state_t         state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
    logic                   parity_q, parity_d;
`endif
    logic                   baud_clr;
    logic                   bit_tick;

    // Timer is held cleared outside the bit-carrying states, so it starts at 0 on entry to START.
    assign baud_clr = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (baud_clr),
        .tick_o  (bit_tick)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
        parity_d   = parity_q;
`endif
        tx_o       = IDLE_LEVEL;
        rd_stb_o   = 1'b0;
        busy_o     = 1'b1;

        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (!rd_empty_i) state_d = POP;
            end
            POP: begin
                rd_stb_o = 1'b1;
                state_d  = LOAD;
            end
            LOAD: begin
                shift_d    = rd_dat_i;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
                parity_d   = ^rd_dat_i;
`endif
                state_d    = START;
            end
            START: begin
                tx_o = START_LEVEL;
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                tx_o = shift_q[0];
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
            PARITY: begin
                tx_o = parity_q;
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench: a behavioural fifo feeds the transmitter and every frame
// is compared cycle by cycle against a waveform built from the byte value.
module tb_uart_tx_fifo_drain;

    localparam int CLK_DIV   = 4;
    localparam int STOP_BITS = 1;
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int NBITS     = 1 + 8 + PAR_BITS + STOP_BITS;
    localparam int FRAME_CYC = NBITS * CLK_DIV;
    localparam int GAP       = FRAME_CYC + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_empty;
    logic       rd_stb;
    logic [7:0] rd_dat = 8'h00;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(
        .CLK_DIV   (CLK_DIV),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rd_empty_i (rd_empty),
        .rd_stb_o   (rd_stb),
        .rd_dat_i   (rd_dat),
        .tx_o       (tx),
        .busy_o     (busy)
    );

    // Behavioural fifo: pushes come from the stimulus, pops from rd_stb with one-cycle data latency.
    logic [7:0] fifo_mem [0:255];
    int         wr_cnt  = 0;
    int         rd_ptr  = 0;
    int         stb_cnt = 0;
    bit         bad_pop = 1'b0;
    int         cyc     = 0;

    assign rd_empty = (wr_cnt == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_stb) begin
            rd_dat  <= fifo_mem[rd_ptr[7:0]];
            rd_ptr  <= rd_ptr + 1;
            stb_cnt <= stb_cnt + 1;
            if (rd_empty) bad_pop <= 1'b1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_cnt[7:0]] = b;
        wr_cnt++;
        exp_q.push_back(b);
    endtask

    // Advances negedge by negedge until tx goes low; t is the cycle stamp of the first start cycle.
    task automatic wait_start(input string tag, output int t);
        bit found = 1'b0;
        t = -1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                t     = cyc;
                break;
            end
        end
        check({tag, "_start_seen"}, 32'(found), 32'd1);
    endtask

    task automatic check_frame(input string tag, output int t);
        logic [7:0]       b;
        logic [NBITS-1:0] bits;
        logic [7:0]       dec;
        int               wave_err;
        int               busy_err;
        wait_start(tag, t);
        if (t < 0) return;
        check({tag, "_exp_avail"}, 32'(exp_q.size() > 0), 32'd1);
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
        bits[9] = ^b;
`endif
        dec      = 8'h00;
        wave_err = 0;
        busy_err = 0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            if (tx !== bits[c / CLK_DIV]) wave_err++;
            if (busy !== 1'b1) busy_err++;
            if ((c % CLK_DIV) == CLK_DIV / 2 && (c / CLK_DIV) >= 1 && (c / CLK_DIV) <= 8)
                dec[(c / CLK_DIV) - 1] = tx;
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
            if ((c % CLK_DIV) == CLK_DIV / 2 && (c / CLK_DIV) == 9)
                check({tag, "_parity"}, 32'(tx), 32'(^b));
`endif
        end
        check({tag, "_byte"}, 32'(dec), 32'(b));
        check({tag, "_wave_err_cycles"}, 32'(wave_err), 32'd0);
        check({tag, "_busy_err_cycles"}, 32'(busy_err), 32'd0);
        @(negedge clk);
        check({tag, "_idle_tx"}, 32'(tx), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int t1, t2, t3, c0, idle_bad, stb0;
        logic [7:0] r;

        // Reset held for 7 cycles with the fifo non-empty.
        rst_n = 1'b0;
        push(8'h5A);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_stb", 32'(rd_stb), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        check("rst_no_pop", 32'(stb_cnt), 32'd0);
        rst_n = 1'b1;
        check_frame("after_rst", t1);

        // Single byte.
        push(8'hA5);
        check_frame("single_a5", t1);
        check("single_stb_cnt", 32'(stb_cnt), 32'd2);

        // Back-to-back frames.
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        check_frame("b2b_00", t1);
        check_frame("b2b_ff", t2);
        check_frame("b2b_55", t3);
        check("b2b_gap1", 32'(t2 - t1), 32'(GAP));
        check("b2b_gap2", 32'(t3 - t2), 32'(GAP));

        // Empty stall, then refill.
        stb0     = stb_cnt;
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        check("stall_idle_bad", 32'(idle_bad), 32'd0);
        check("stall_no_stb", 32'(stb_cnt - stb0), 32'd0);
        push(8'h3C);
        c0 = cyc;
        check_frame("refill_3c", t1);
        check("refill_latency", 32'(t1 - c0), 32'd3);

        // Reset during data bit 3; the in-flight byte is dropped, the next one goes out whole.
        push(8'hC3);
        push(8'h96);
        wait_start("midrst", t1);
        repeat (4 * CLK_DIV + 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_stb", 32'(rd_stb), 32'd0);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        check_frame("midrst_next", t2);

        // Parity-discriminating bytes (plain frames when parity is disabled).
        push(8'h07);
        check_frame("par_07", t1);
        push(8'h03);
        check_frame("par_03", t1);

        // Random bursts with random idle gaps.
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                r = 8'($urandom);
                push(r);
            end
            for (int j = 0; j < n; j++) check_frame("rand", t1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        check("final_pop_count", 32'(stb_cnt), 32'(wr_cnt));
        check("final_no_empty_pop", 32'(bad_pop), 32'd0);
        check("final_exp_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
